// File: rtl/pattern_fsm_pkg.sv
// Shared state encoding for the serial pattern-detect controller.
// One-hot states; STATE_W is the width of the debug state output.
package pattern_fsm_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 4'b0001,
        ARM  = 4'b0010,
        HIT  = 4'b0100,
        LOCK = 4'b1000
    } state_t;

endpackage

// File: rtl/pattern_fsm_if.sv
// Control/data bundle between a serial front end and the pattern detector.
// pat_mask exists only when PATTERN_FSM_MASK_EN is defined.
interface pattern_fsm_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    import pattern_fsm_pkg::*;

    logic               din_vld;
    logic               din;
    logic [PAT_W-1:0]   pat;
`ifdef PATTERN_FSM_MASK_EN
    logic [PAT_W-1:0]   pat_mask;
`endif
    logic               overlap;
    logic [CNT_W-1:0]   max_hits;
    logic               start;
    logic               stop;
    logic               clr;
    logic               hit;
    logic [CNT_W-1:0]   hit_cnt;
    logic               locked;
    logic [STATE_W-1:0] state_o;

    modport master (
`ifdef PATTERN_FSM_MASK_EN
        output pat_mask,
`endif
        output din_vld, din, pat, overlap, max_hits, start, stop, clr,
        input  hit, hit_cnt, locked, state_o
    );

    modport slave (
`ifdef PATTERN_FSM_MASK_EN
        input  pat_mask,
`endif
        input  din_vld, din, pat, overlap, max_hits, start, stop, clr,
        output hit, hit_cnt, locked, state_o
    );

endinterface

// File: rtl/pattern_fsm_match.sv
// Combinational compare of the shifted bit window against the pattern.
// With PATTERN_FSM_MASK_EN, only bits whose mask bit is 1 take part.
module pattern_fsm_match #(
    parameter int PAT_W = 4
) (
    input  logic [PAT_W-1:0] i_win,
    input  logic [PAT_W-1:0] i_pat,
`ifdef PATTERN_FSM_MASK_EN
    input  logic [PAT_W-1:0] i_mask,
`endif
    output logic             o_eq
);

`ifdef PATTERN_FSM_MASK_EN
    assign o_eq = (((i_win ^ i_pat) & i_mask) == '0);
`else
    assign o_eq = (i_win == i_pat);
`endif

endmodule

// File: rtl/pattern_fsm.sv
// Serial pattern detector: one-hot FSM, history register, fill count, saturating hit counter.
// hit/hit_cnt/locked are registered, one cycle after the completing bit. Option: PATTERN_FSM_MASK_EN.
module pattern_fsm
    import pattern_fsm_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic         sclk,
    input  logic         rst_n,
    pattern_fsm_if.slave bus
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PAT_W - 1);

    state_t             r_state;
    // Only the newest PAT_W-1 bits are kept; the incoming bit completes the window.
    logic [PAT_W-2:0]   r_shreg;
    logic [FILL_W-1:0]  r_fill;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_hit;
    logic               r_locked;

    logic [PAT_W-1:0]   w_win;
    logic               w_eq;
    logic               w_match;
    logic [FILL_W-1:0]  w_fill_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_lock_now;

    assign w_win      = {r_shreg, bus.din};
    assign w_match    = bus.din_vld && (r_fill >= FILL_THR) && w_eq;
    assign w_fill_nxt = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;
    assign w_cnt_nxt  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_lock_now = (bus.max_hits != '0) && (w_cnt_nxt == bus.max_hits);

    pattern_fsm_match #(
        .PAT_W (PAT_W)
    ) u_match (
        .i_win  (w_win),
        .i_pat  (bus.pat),
`ifdef PATTERN_FSM_MASK_EN
        .i_mask (bus.pat_mask),
`endif
        .o_eq   (w_eq)
    );

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_fill   <= '0;
            r_cnt    <= '0;
            r_hit    <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_hit <= 1'b0;
            if (bus.clr) begin
                r_state  <= IDLE;
                r_shreg  <= '0;
                r_fill   <= '0;
                r_cnt    <= '0;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start) begin
                            r_state <= ARM;
                        end
                    end
                    ARM, HIT: begin
                        if (bus.stop) begin
                            r_state <= IDLE;
                            r_shreg <= '0;
                            r_fill  <= '0;
                        end else begin
                            r_state <= ARM;
                            if (bus.din_vld) begin
                                r_shreg <= w_win[PAT_W-2:0];
                                r_fill  <= w_fill_nxt;
                            end
                            if (w_match) begin
                                r_hit <= 1'b1;
                                r_cnt <= w_cnt_nxt;
                                if (w_lock_now) begin
                                    r_state  <= LOCK;
                                    r_locked <= 1'b1;
                                end else begin
                                    r_state <= HIT;
                                end
                                // Non-overlapping: the next match needs a full fresh window.
                                if (!bus.overlap) begin
                                    r_shreg <= '0;
                                    r_fill  <= '0;
                                end
                            end
                        end
                    end
                    LOCK: begin
                        r_state <= LOCK;
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.hit     = r_hit;
    assign bus.hit_cnt = r_cnt;
    assign bus.locked  = r_locked;
    assign bus.state_o = r_state;

endmodule

// File: tb/tb_pattern_fsm.sv
// Directed bench for pattern_fsm: main instance CNT_W=8, second instance CNT_W=2 for saturation.
module tb_pattern_fsm;
    import pattern_fsm_pkg::*;

    logic sclk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    pattern_fsm_if #(.PAT_W(4), .CNT_W(8)) if1 ();
    pattern_fsm_if #(.PAT_W(4), .CNT_W(2)) if2 ();

    pattern_fsm #(.PAT_W(4), .CNT_W(8)) u_dut  (.sclk(sclk), .rst_n(rst_n), .bus(if1.slave));
    pattern_fsm #(.PAT_W(4), .CNT_W(2)) u_dut2 (.sclk(sclk), .rst_n(rst_n), .bus(if2.slave));

    always #5 sclk = ~sclk;

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic init_inputs();
        if1.din_vld = 0; if1.din = 0; if1.pat = 4'b1011; if1.overlap = 0;
        if1.max_hits = 0; if1.start = 0; if1.stop = 0; if1.clr = 0;
        if2.din_vld = 0; if2.din = 0; if2.pat = 4'b1011; if2.overlap = 1;
        if2.max_hits = 0; if2.start = 0; if2.stop = 0; if2.clr = 0;
`ifdef PATTERN_FSM_MASK_EN
        if1.pat_mask = 4'b1111;
        if2.pat_mask = 4'b1111;
`endif
    endtask

    // Drive one valid bit on the main instance; returns hit as seen after the edge.
    task automatic send1(input logic b, output logic h);
        if1.din_vld = 1; if1.din = b;
        tick();
        if1.din_vld = 0;
        h = if1.hit;
    endtask

    task automatic clear_and_start();
        if1.clr = 1; tick(); if1.clr = 0;
        if1.start = 1; tick(); if1.start = 0;
    endtask

    task automatic test_reset();
        n_total++; if (if1.state_o !== 4'b0001) $display("FAIL reset_state got %b exp 0001", if1.state_o); else n_pass++;
        n_total++; if (if1.hit !== 1'b0) $display("FAIL reset_hit got %b exp 0", if1.hit); else n_pass++;
        n_total++; if (if1.hit_cnt !== 8'd0) $display("FAIL reset_cnt got %0d exp 0", if1.hit_cnt); else n_pass++;
        n_total++; if (if1.locked !== 1'b0) $display("FAIL reset_locked got %b exp 0", if1.locked); else n_pass++;
    endtask

    task automatic test_non_overlap();
        logic [6:0] bits = 7'b1011011;
        logic [6:0] hv = '0;
        logic h;
        if1.overlap = 0; if1.max_hits = 0;
        clear_and_start();
        n_total++; if (if1.state_o !== 4'b0010) $display("FAIL nov_arm got %b exp 0010", if1.state_o); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            send1(bits[6-i], h);
            hv[i] = h;
            if (i == 3) begin
                n_total++; if (if1.state_o !== 4'b0100) $display("FAIL nov_hit_state got %b exp 0100", if1.state_o); else n_pass++;
            end
        end
        n_total++; if (hv !== 7'b0001000) $display("FAIL nov_hits got %b exp 0001000", hv); else n_pass++;
        n_total++; if (if1.hit_cnt !== 8'd1) $display("FAIL nov_cnt got %0d exp 1", if1.hit_cnt); else n_pass++;
    endtask

    task automatic test_overlap();
        logic [6:0] bits = 7'b1011011;
        logic [6:0] hv = '0;
        logic h;
        if1.overlap = 1; if1.max_hits = 0;
        clear_and_start();
        for (int i = 0; i < 7; i++) begin
            send1(bits[6-i], h);
            hv[i] = h;
        end
        n_total++; if (hv !== 7'b1001000) $display("FAIL ov_hits got %b exp 1001000", hv); else n_pass++;
        n_total++; if (if1.hit_cnt !== 8'd2) $display("FAIL ov_cnt got %0d exp 2", if1.hit_cnt); else n_pass++;
    endtask

    task automatic test_valid_gaps();
        logic [3:0] bits = 4'b1011;
        int   nhits = 0;
        logic h;
        logic h4 = 0;
        if1.overlap = 0; if1.max_hits = 0;
        clear_and_start();
        for (int i = 0; i < 4; i++) begin
            send1(bits[3-i], h);
            if (h) nhits++;
            if (i == 3) h4 = h;
            for (int g = 0; g < 3; g++) begin
                tick();
                if (if1.hit) nhits++;
            end
        end
        n_total++; if (h4 !== 1'b1) $display("FAIL gap_hit4 got %b exp 1", h4); else n_pass++;
        n_total++; if (nhits != 1) $display("FAIL gap_nhits got %0d exp 1", nhits); else n_pass++;
        n_total++; if (if1.hit_cnt !== 8'd1) $display("FAIL gap_cnt got %0d exp 1", if1.hit_cnt); else n_pass++;
    endtask

    task automatic test_lock();
        logic [9:0] bits = 10'b1011011011;
        logic [9:0] hv = '0;
        logic h;
        if1.overlap = 1; if1.max_hits = 8'd2;
        clear_and_start();
        for (int i = 0; i < 10; i++) begin
            send1(bits[9-i], h);
            hv[i] = h;
            if (i == 6) begin
                n_total++; if (if1.locked !== 1'b1) $display("FAIL lock_rise got %b exp 1", if1.locked); else n_pass++;
            end
        end
        n_total++; if (hv !== 10'b0001001000) $display("FAIL lock_hits got %b exp 0001001000", hv); else n_pass++;
        n_total++; if (if1.hit_cnt !== 8'd2) $display("FAIL lock_cnt got %0d exp 2", if1.hit_cnt); else n_pass++;
        if1.stop = 1; tick(); if1.stop = 0;
        if1.start = 1; tick(); if1.start = 0;
        n_total++; if (if1.state_o !== 4'b1000) $display("FAIL lock_hold got %b exp 1000", if1.state_o); else n_pass++;
        if1.clr = 1; tick(); if1.clr = 0;
        n_total++; if (if1.state_o !== 4'b0001) $display("FAIL lock_clr_state got %b exp 0001", if1.state_o); else n_pass++;
        n_total++; if (if1.hit_cnt !== 8'd0) $display("FAIL lock_clr_cnt got %0d exp 0", if1.hit_cnt); else n_pass++;
        n_total++; if (if1.locked !== 1'b0) $display("FAIL lock_clr_locked got %b exp 0", if1.locked); else n_pass++;
        if1.max_hits = 0;
    endtask

    task automatic test_stop_clr_midstream();
        logic h;
        if1.overlap = 0; if1.max_hits = 0;
        clear_and_start();
        send1(1, h); send1(0, h); send1(1, h); send1(1, h);
        send1(1, h); send1(0, h); send1(1, h);
        if1.stop = 1;
        send1(1, h);
        if1.stop = 0;
        n_total++; if (h !== 1'b0) $display("FAIL stop_hit got %b exp 0", h); else n_pass++;
        n_total++; if (if1.state_o !== 4'b0001) $display("FAIL stop_state got %b exp 0001", if1.state_o); else n_pass++;
        n_total++; if (if1.hit_cnt !== 8'd1) $display("FAIL stop_cnt got %0d exp 1", if1.hit_cnt); else n_pass++;
        if1.start = 1; tick(); if1.start = 0;
        send1(1, h); send1(0, h); send1(1, h);
        if1.clr = 1;
        send1(1, h);
        if1.clr = 0;
        n_total++; if (h !== 1'b0) $display("FAIL clr_hit got %b exp 0", h); else n_pass++;
        n_total++; if (if1.hit_cnt !== 8'd0) $display("FAIL clr_cnt got %0d exp 0", if1.hit_cnt); else n_pass++;
        n_total++; if (if1.state_o !== 4'b0001) $display("FAIL clr_state got %b exp 0001", if1.state_o); else n_pass++;
    endtask

    task automatic test_saturate();
        logic [15:0] bits = 16'b1011011011011011;
        int nhits = 0;
        if2.start = 1; tick(); if2.start = 0;
        for (int i = 0; i < 16; i++) begin
            if2.din_vld = 1; if2.din = bits[15-i];
            tick();
            if2.din_vld = 0;
            if (if2.hit) nhits++;
        end
        n_total++; if (nhits != 5) $display("FAIL sat_nhits got %0d exp 5", nhits); else n_pass++;
        n_total++; if (if2.hit_cnt !== 2'd3) $display("FAIL sat_cnt got %0d exp 3", if2.hit_cnt); else n_pass++;
        n_total++; if (if2.state_o !== 4'b0100) $display("FAIL sat_state got %b exp 0100", if2.state_o); else n_pass++;
        n_total++; if (if2.locked !== 1'b0) $display("FAIL sat_locked got %b exp 0", if2.locked); else n_pass++;
    endtask

    task automatic test_reset_mid_hit();
        logic h;
        if1.overlap = 0; if1.max_hits = 0;
        clear_and_start();
        send1(1, h); send1(0, h); send1(1, h); send1(1, h);
        n_total++; if (h !== 1'b1) $display("FAIL rst_pre_hit got %b exp 1", h); else n_pass++;
        rst_n = 0;
        #1;
        n_total++; if (if1.hit !== 1'b0) $display("FAIL rst_hit got %b exp 0", if1.hit); else n_pass++;
        n_total++; if (if1.state_o !== 4'b0001) $display("FAIL rst_state got %b exp 0001", if1.state_o); else n_pass++;
        n_total++; if (if1.hit_cnt !== 8'd0) $display("FAIL rst_cnt got %0d exp 0", if1.hit_cnt); else n_pass++;
        n_total++; if (if1.locked !== 1'b0) $display("FAIL rst_locked got %b exp 0", if1.locked); else n_pass++;
        tick();
        rst_n = 1;
        tick();
        n_total++; if (if1.state_o !== 4'b0001) $display("FAIL rst_after_state got %b exp 0001", if1.state_o); else n_pass++;
    endtask

    initial begin
        init_inputs();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
        test_reset();
        test_non_overlap();
        test_overlap();
        test_valid_gaps();
        test_lock();
        test_stop_clr_midstream();
        test_saturate();
        test_reset_mid_hit();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
